// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: register width,
// counter width and the EX-stage operand select encodings.
package hazard_pkg;

  localparam int REG_W = 5;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_e;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Operand source comparator: picks the youngest in-flight producer of one
// source register, or the register file when nothing in flight writes it.
module fwd_sel #(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] src,
  input  logic             ex_regwrite,
  input  logic             ex_valid,
  input  logic [REG_W-1:0] ex_writereg,
  input  logic             mem_regwrite,
  input  logic             mem_valid,
  input  logic [REG_W-1:0] mem_writereg,
  output logic [1:0]       sel
);
  import hazard_pkg::*;

  logic ex_hit;
  logic mem_hit;

  // $0 is hardwired to zero, so a write to it is never a real producer
  assign ex_hit  = ex_regwrite && ex_valid && (ex_writereg != '0) && (ex_writereg == src);
  assign mem_hit = mem_regwrite && mem_valid && (mem_writereg != '0) && (mem_writereg == src);

  always_comb begin
    sel = FWD_REG;
    if (ex_hit) begin
      sel = FWD_MEM;
    end else if (mem_hit) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: load-use stall,
// branch/jump flushes, forwarding and bypass selects, stage valids, counters.
module hazard_ctrl #(
  parameter int CNT_W = 16,
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic             ex_memread,
  input  logic             ex_regwrite,
  input  logic [REG_W-1:0] ex_writereg,
  input  logic             mem_regwrite,
  input  logic [REG_W-1:0] mem_writereg,
  input  logic             mem_pcsrc,
  input  logic             wb_regwrite,
  input  logic [REG_W-1:0] wb_writereg,
  output logic             pc_write,
  output logic             jump_take,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             byp_a,
  output logic             byp_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] retire_cnt
);
  import hazard_pkg::*;

  logic       valid_id;
  logic       valid_ex;
  logic       valid_mem;
  logic       valid_wb;
  logic       load_use;
  logic       stall;
  logic [1:0] sel_a;
  logic [1:0] sel_b;

  assign load_use = ex_memread && valid_ex && (ex_writereg != '0) &&
                    ((ex_writereg == id_rs) || (id_uses_rt && (ex_writereg == id_rt)));

  // Branch beats load-use beats jump; reset forces the idle, free-running state
  always_comb begin
    stall       = 1'b0;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    jump_take   = 1'b0;
    if (!rst) begin
      if (mem_pcsrc) begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
      end else if (load_use) begin
        stall      = 1'b1;
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_flush = 1'b1;
      end else if (id_jump) begin
        jump_take  = 1'b1;
        ifid_flush = 1'b1;
      end
    end
  end

  fwd_sel #(.REG_W(REG_W)) u_fwd_rs (
    .src          (id_rs),
    .ex_regwrite  (ex_regwrite),
    .ex_valid     (valid_ex),
    .ex_writereg  (ex_writereg),
    .mem_regwrite (mem_regwrite),
    .mem_valid    (valid_mem),
    .mem_writereg (mem_writereg),
    .sel          (sel_a)
  );

  fwd_sel #(.REG_W(REG_W)) u_fwd_rt (
    .src          (id_rt),
    .ex_regwrite  (ex_regwrite),
    .ex_valid     (valid_ex),
    .ex_writereg  (ex_writereg),
    .mem_regwrite (mem_regwrite),
    .mem_valid    (valid_mem),
    .mem_writereg (mem_writereg),
    .sel          (sel_b)
  );

  // The regfile write lands at the edge, so an ID read of the WB register is stale
  assign byp_a = wb_regwrite && (wb_writereg != '0) && (wb_writereg == id_rs);
  assign byp_b = wb_regwrite && (wb_writereg != '0) && (wb_writereg == id_rt);

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_a      <= FWD_REG;
      fwd_b      <= FWD_REG;
      valid_id   <= 1'b0;
      valid_ex   <= 1'b0;
      valid_mem  <= 1'b0;
      valid_wb   <= 1'b0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      retire_cnt <= '0;
    end else begin
      // A bubble entering EX carries no operands worth forwarding
      fwd_a <= idex_flush ? FWD_REG : sel_a;
      fwd_b <= idex_flush ? FWD_REG : sel_b;
      if (!stall) begin
        valid_id <= !ifid_flush;
      end
      valid_ex  <= valid_id && !idex_flush;
      valid_mem <= valid_ex && !exmem_flush;
      valid_wb  <= valid_mem;
      if (stall) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (mem_pcsrc || jump_take) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
      if (valid_wb) begin
        retire_cnt <= retire_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized self-checking bench for hazard_ctrl against a stage-occupancy
// reference model, followed by a long hazard-free run to wrap retire_cnt.
module tb_hazard_ctrl;

  localparam int CNT_W = 16;
  localparam int REG_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic [REG_W-1:0] id_rs, id_rt, ex_writereg, mem_writereg, wb_writereg;
  logic             id_uses_rt, id_jump, ex_memread, ex_regwrite;
  logic             mem_regwrite, mem_pcsrc, wb_regwrite;
  logic             pc_write, jump_take, ifid_write, ifid_flush, idex_flush, exmem_flush;
  logic [1:0]       fwd_a, fwd_b;
  logic             byp_a, byp_b;
  logic [CNT_W-1:0] stall_cnt, flush_cnt, retire_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: which of ID, EX, MEM, WB hold a live instruction
  bit       occ[4];
  bit [1:0] m_fwd_a, m_fwd_b;
  int       m_stall, m_flush, m_retire;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(CNT_W), .REG_W(REG_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .id_jump      (id_jump),
    .ex_memread   (ex_memread),
    .ex_regwrite  (ex_regwrite),
    .ex_writereg  (ex_writereg),
    .mem_regwrite (mem_regwrite),
    .mem_writereg (mem_writereg),
    .mem_pcsrc    (mem_pcsrc),
    .wb_regwrite  (wb_regwrite),
    .wb_writereg  (wb_writereg),
    .pc_write     (pc_write),
    .jump_take    (jump_take),
    .ifid_write   (ifid_write),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .exmem_flush  (exmem_flush),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .byp_a        (byp_a),
    .byp_b        (byp_b),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt),
    .retire_cnt   (retire_cnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit writes(input bit we, input bit live, input logic [REG_W-1:0] dst,
                                input logic [REG_W-1:0] src);
    return we && live && (dst != 0) && (dst == src);
  endfunction

  // Youngest live producer of src wins: EX result (10), then MEM result (01)
  function automatic bit [1:0] producer(input logic [REG_W-1:0] src);
    if (writes(ex_regwrite, occ[1], ex_writereg, src)) return 2'b10;
    if (writes(mem_regwrite, occ[2], mem_writereg, src)) return 2'b01;
    return 2'b00;
  endfunction

  task automatic applyStimulus(input bit quiet);
    rst          = !quiet && ($urandom_range(63) == 0);
    id_rs        = REG_W'($urandom_range(3));
    id_rt        = REG_W'($urandom_range(3));
    id_uses_rt   = 1'($urandom_range(1));
    id_jump      = !quiet && ($urandom_range(5) == 0);
    ex_memread   = !quiet && ($urandom_range(1) == 0);
    ex_regwrite  = 1'($urandom_range(1));
    ex_writereg  = REG_W'($urandom_range(3));
    mem_regwrite = 1'($urandom_range(1));
    mem_writereg = REG_W'($urandom_range(3));
    mem_pcsrc    = !quiet && ($urandom_range(7) == 0);
    wb_regwrite  = 1'($urandom_range(1));
    wb_writereg  = REG_W'($urandom_range(7));
  endtask

  task automatic step(input bit quiet);
    bit hazard, e_stall, e_jump, e_branch, e_ifid_fl, e_idex_fl, e_exmem_fl;
    bit [3:0] nxt;
    @(negedge clk);
    applyStimulus(quiet);
    #1;
    e_branch   = !rst && mem_pcsrc;
    hazard     = ex_memread && occ[1] &&
                 (writes(1'b1, 1'b1, ex_writereg, id_rs) ||
                  (id_uses_rt && writes(1'b1, 1'b1, ex_writereg, id_rt)));
    e_stall    = !rst && !e_branch && hazard;
    e_jump     = !rst && !e_branch && !e_stall && id_jump;
    e_ifid_fl  = e_branch || e_jump;
    e_idex_fl  = e_branch || e_stall;
    e_exmem_fl = e_branch;

    checkOutput("pc_write", pc_write, !e_stall);
    checkOutput("ifid_write", ifid_write, !e_stall);
    checkOutput("jump_take", jump_take, e_jump);
    checkOutput("ifid_flush", ifid_flush, e_ifid_fl);
    checkOutput("idex_flush", idex_flush, e_idex_fl);
    checkOutput("exmem_flush", exmem_flush, e_exmem_fl);
    checkOutput("byp_a", byp_a, writes(wb_regwrite, 1'b1, wb_writereg, id_rs));
    checkOutput("byp_b", byp_b, writes(wb_regwrite, 1'b1, wb_writereg, id_rt));
    checkOutput("fwd_a", fwd_a, m_fwd_a);
    checkOutput("fwd_b", fwd_b, m_fwd_b);
    checkOutput("stall_cnt", stall_cnt, 32'(m_stall));
    checkOutput("flush_cnt", flush_cnt, 32'(m_flush));
    checkOutput("retire_cnt", retire_cnt, 32'(m_retire));

    @(posedge clk);
    if (rst) begin
      occ = '{default: 1'b0};
      m_fwd_a = 2'b00;
      m_fwd_b = 2'b00;
      m_stall = 0;
      m_flush = 0;
      m_retire = 0;
    end else begin
      m_retire = (m_retire + int'(occ[3])) % 65536;
      m_stall  = (m_stall + int'(e_stall)) % 65536;
      m_flush  = (m_flush + int'(e_ifid_fl)) % 65536;
      m_fwd_a  = e_idex_fl ? 2'b00 : producer(id_rs);
      m_fwd_b  = e_idex_fl ? 2'b00 : producer(id_rt);
      nxt[0] = e_stall ? occ[0] : !e_ifid_fl;
      nxt[1] = occ[0] && !e_idex_fl;
      nxt[2] = occ[1] && !e_exmem_fl;
      nxt[3] = occ[2];
      for (int i = 0; i < 4; i++) occ[i] = nxt[i];
    end
  endtask

  initial begin
    int budget;
    rst = 1'b1;
    id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; id_jump = 1'b0;
    ex_memread = 1'b0; ex_regwrite = 1'b0; ex_writereg = '0;
    mem_regwrite = 1'b0; mem_writereg = '0; mem_pcsrc = 1'b0;
    wb_regwrite = 1'b0; wb_writereg = '0;
    occ = '{default: 1'b0};
    m_fwd_a = 2'b00; m_fwd_b = 2'b00;
    m_stall = 0; m_flush = 0; m_retire = 0;
    repeat (2) @(posedge clk);

    for (int n = 0; n < 3000; n++) step(1'b0);

    budget = 70000;
    while (m_retire != 65535 && budget > 0) begin
      step(1'b1);
      budget--;
    end
    if (budget == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL retire_budget: got %0h expected ffff", retire_cnt);
    end else begin
      #1;
      checkOutput("retire_max", retire_cnt, 32'h0000_FFFF);
      step(1'b1);
      #1;
      checkOutput("retire_wrap", retire_cnt, 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
